// File: rtl/writeback_unit.sv
// Write-back stage: merges single-cycle ALU results with buffered load responses
// into one registered warp-wide register-file write per cycle; ALU has priority.
module writeback_unit #(
  parameter int unsigned R_DATA_WIDTH   = 32,
  parameter int unsigned R_ADDR_WIDTH   = 10,
  parameter int unsigned SP_PER_MP      = 8,
  parameter int unsigned MEM_FIFO_DEPTH = 4,
  parameter int unsigned STARVE_LIMIT   = 3
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 alu_valid_x,
  input  logic [SP_PER_MP-1:0]                 alu_mask_x,
  input  logic [R_ADDR_WIDTH-1:0]              alu_rwa_x,
  input  logic [SP_PER_MP*R_DATA_WIDTH-1:0]    alu_data_x,
  input  logic                                 mem_valid_m,
  output logic                                 mem_ready_m,
  input  logic [SP_PER_MP-1:0]                 mem_mask_m,
  input  logic [R_ADDR_WIDTH-1:0]              mem_rwa_m,
  input  logic [SP_PER_MP*R_DATA_WIDTH-1:0]    mem_data_m,
  output logic                                 stall_x,
  output logic                                 mem_pending,
  output logic [SP_PER_MP-1:0]                 rwe_wb,
  output logic [R_ADDR_WIDTH-1:0]              rwa_wb,
  output logic [SP_PER_MP*R_DATA_WIDTH-1:0]    rdata_wb
);

  localparam int unsigned DATA_W  = SP_PER_MP * R_DATA_WIDTH;
  localparam int unsigned ENTRY_W = SP_PER_MP + R_ADDR_WIDTH + DATA_W;
  localparam int unsigned PTR_W   = $clog2(MEM_FIFO_DEPTH);
  localparam int unsigned CNT_W   = $clog2(MEM_FIFO_DEPTH + 1);
  localparam int unsigned STV_W   = $clog2(STARVE_LIMIT + 1);

  logic [ENTRY_W-1:0]      fifo_q [MEM_FIFO_DEPTH];
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]        count_q, count_d;
  logic [STV_W-1:0]        starve_q, starve_d;
  logic [SP_PER_MP-1:0]    rwe_q, rwe_d;
  logic [R_ADDR_WIDTH-1:0] rwa_q, rwa_d;
  logic [DATA_W-1:0]       rdata_q, rdata_d;

  logic               fifo_empty;
  logic               push;
  logic               pop;
  logic [ENTRY_W-1:0] head;

  assign fifo_empty  = (count_q == '0);
  assign mem_ready_m = !rst && (count_q < CNT_W'(MEM_FIFO_DEPTH));
  assign stall_x     = !rst && (starve_q == STV_W'(STARVE_LIMIT));
  assign mem_pending = !fifo_empty;
  assign push        = mem_valid_m && mem_ready_m;
  assign pop         = !alu_valid_x && !fifo_empty;
  assign head        = fifo_q[rd_ptr_q];

  assign rwe_wb   = rwe_q;
  assign rwa_wb   = rwa_q;
  assign rdata_wb = rdata_q;

  // Write-port selection, FIFO bookkeeping and starvation guard.
  always_comb begin
    rwe_d    = '0;
    rwa_d    = rwa_q;
    rdata_d  = rdata_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    starve_d = starve_q;

    if (alu_valid_x) begin
      rwe_d   = alu_mask_x;
      rwa_d   = alu_rwa_x;
      rdata_d = alu_data_x;
    end else if (pop) begin
      rwe_d   = head[ENTRY_W-1 -: SP_PER_MP];
      rwa_d   = head[DATA_W +: R_ADDR_WIDTH];
      rdata_d = head[DATA_W-1:0];
    end

    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Counts cycles a buffered load loses to the ALU; any pop resets it.
    if (pop || fifo_empty) begin
      starve_d = '0;
    end else if (alu_valid_x && (starve_q != STV_W'(STARVE_LIMIT))) begin
      starve_d = starve_q + STV_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      starve_q <= '0;
      rwe_q    <= '0;
      rwa_q    <= '0;
      rdata_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      starve_q <= starve_d;
      rwe_q    <= rwe_d;
      rwa_q    <= rwa_d;
      rdata_q  <= rdata_d;
    end
  end

  // Storage needs no reset: occupancy is tracked by count_q alone.
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= {mem_mask_m, mem_rwa_m, mem_data_m};
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// Directed bench for writeback_unit: ALU/load arbitration, FIFO order,
// starvation stall, reset flush and zero-mask slots.
module tb_writeback_unit;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;
  localparam int unsigned NL = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            alu_valid_x;
  logic [NL-1:0]   alu_mask_x;
  logic [AW-1:0]   alu_rwa_x;
  logic [NL*DW-1:0] alu_data_x;
  logic            mem_valid_m;
  logic            mem_ready_m;
  logic [NL-1:0]   mem_mask_m;
  logic [AW-1:0]   mem_rwa_m;
  logic [NL*DW-1:0] mem_data_m;
  logic            stall_x;
  logic            mem_pending;
  logic [NL-1:0]   rwe_wb;
  logic [AW-1:0]   rwa_wb;
  logic [NL*DW-1:0] rdata_wb;

  int n_total = 0;
  int n_bad   = 0;

  writeback_unit dut (
    .clk         (clk),
    .rst         (rst),
    .alu_valid_x (alu_valid_x),
    .alu_mask_x  (alu_mask_x),
    .alu_rwa_x   (alu_rwa_x),
    .alu_data_x  (alu_data_x),
    .mem_valid_m (mem_valid_m),
    .mem_ready_m (mem_ready_m),
    .mem_mask_m  (mem_mask_m),
    .mem_rwa_m   (mem_rwa_m),
    .mem_data_m  (mem_data_m),
    .stall_x     (stall_x),
    .mem_pending (mem_pending),
    .rwe_wb      (rwe_wb),
    .rwa_wb      (rwa_wb),
    .rdata_wb    (rdata_wb)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [NL*DW-1:0] mk_data(input logic [31:0] base);
    logic [NL*DW-1:0] d;
    for (int i = 0; i < int'(NL); i++) d[i*DW +: DW] = base + 32'(i);
    return d;
  endfunction

  function automatic logic [AW-1:0] ld_rwa(input int k);
    return 10'h140 + 10'(k);
  endfunction

  function automatic logic [NL-1:0] ld_mask(input int k);
    return 8'h80 | (8'h01 << k);
  endfunction

  function automatic logic [31:0] ld_base(input int k);
    return 32'hA000 + 32'(k * 16);
  endfunction

  task automatic set_load(input int k);
    mem_rwa_m  = ld_rwa(k);
    mem_mask_m = ld_mask(k);
    mem_data_m = mk_data(ld_base(k));
  endtask

  initial begin
    rst = 1'b1; alu_valid_x = 1'b0; alu_mask_x = '0; alu_rwa_x = '0; alu_data_x = '0;
    mem_valid_m = 1'b0; mem_mask_m = '0; mem_rwa_m = '0; mem_data_m = '0;

    // Reset state
    tick(); tick();
    chk("rst_rwe", 256'(rwe_wb), 256'h0);
    chk("rst_rwa", 256'(rwa_wb), 256'h0);
    chk("rst_rdata", 256'(rdata_wb), 256'h0);
    chk("rst_pending", 256'(mem_pending), 256'h0);
    chk("rst_ready", 256'(mem_ready_m), 256'h0);
    chk("rst_stall", 256'(stall_x), 256'h0);
    rst = 1'b0; #1;
    chk("post_rst_ready", 256'(mem_ready_m), 256'h1);

    // Single ALU write
    alu_valid_x = 1'b1; alu_mask_x = 8'hFF; alu_rwa_x = 10'h025; alu_data_x = mk_data(32'h0);
    tick();
    chk("alu_rwe", 256'(rwe_wb), 256'hFF);
    chk("alu_rwa", 256'(rwa_wb), 256'h025);
    chk("alu_lane0", 256'(rdata_wb[0 +: 32]), 256'h0);
    chk("alu_lane7", 256'(rdata_wb[7*32 +: 32]), 256'h7);
    alu_valid_x = 1'b0;
    tick();
    chk("idle_rwe", 256'(rwe_wb), 256'h0);
    chk("idle_rwa_hold", 256'(rwa_wb), 256'h025);
    chk("idle_rdata_hold", 256'(rdata_wb[3*32 +: 32]), 256'h3);

    // Load only: written two cycles after accept
    mem_valid_m = 1'b1; mem_rwa_m = 10'h100; mem_mask_m = 8'h0F; mem_data_m = mk_data(32'h1000);
    tick();
    mem_valid_m = 1'b0;
    chk("ld_lat1_rwe", 256'(rwe_wb), 256'h0);
    chk("ld_lat1_pending", 256'(mem_pending), 256'h1);
    tick();
    chk("ld_rwe", 256'(rwe_wb), 256'h0F);
    chk("ld_rwa", 256'(rwa_wb), 256'h100);
    chk("ld_lane2", 256'(rdata_wb[2*32 +: 32]), 256'h1002);
    chk("ld_pending_clr", 256'(mem_pending), 256'h0);

    // ALU every cycle while five loads are offered
    alu_valid_x = 1'b1; alu_mask_x = 8'hFF; mem_valid_m = 1'b1;
    for (int k = 0; k < 4; k++) begin
      alu_rwa_x  = 10'h200 + 10'(k);
      alu_data_x = mk_data(32'h5000 + 32'(k * 256));
      set_load(k);
      chk($sformatf("fill_ready%0d", k), 256'(mem_ready_m), 256'h1);
      tick();
      chk($sformatf("fill_rwa%0d", k), 256'(rwa_wb), 256'(10'h200 + 10'(k)));
      chk($sformatf("fill_rwe%0d", k), 256'(rwe_wb), 256'hFF);
      chk($sformatf("fill_stall%0d", k), 256'(stall_x), (k == 3) ? 256'h1 : 256'h0);
    end
    set_load(4);
    chk("full_ready", 256'(mem_ready_m), 256'h0);
    // Execute ignores stall: ALU still wins, stall persists
    alu_rwa_x = 10'h204; alu_data_x = mk_data(32'h5400);
    tick();
    chk("ign_rwa", 256'(rwa_wb), 256'h204);
    chk("ign_stall", 256'(stall_x), 256'h1);
    chk("ign_ready", 256'(mem_ready_m), 256'h0);
    alu_valid_x = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (k == 1) mem_valid_m = 1'b0;
      chk($sformatf("drain_rwa%0d", k), 256'(rwa_wb), 256'(ld_rwa(k)));
      chk($sformatf("drain_rwe%0d", k), 256'(rwe_wb), 256'(ld_mask(k)));
      chk($sformatf("drain_lane1_%0d", k), 256'(rdata_wb[1*32 +: 32]), 256'(ld_base(k) + 32'd1));
      if (k == 0) begin
        chk("drain_stall_drop", 256'(stall_x), 256'h0);
        chk("drain_ready", 256'(mem_ready_m), 256'h1);
      end
    end
    chk("drain_pending", 256'(mem_pending), 256'h0);

    // Simultaneous ALU and load into empty FIFO
    alu_valid_x = 1'b1; alu_mask_x = 8'h3C; alu_rwa_x = 10'h055; alu_data_x = mk_data(32'h7700);
    mem_valid_m = 1'b1; mem_mask_m = 8'hC3; mem_rwa_m = 10'h0AA; mem_data_m = mk_data(32'h8800);
    tick();
    alu_valid_x = 1'b0; mem_valid_m = 1'b0;
    chk("sim_alu_rwa", 256'(rwa_wb), 256'h055);
    chk("sim_alu_rwe", 256'(rwe_wb), 256'h3C);
    tick();
    chk("sim_ld_rwa", 256'(rwa_wb), 256'h0AA);
    chk("sim_ld_rwe", 256'(rwe_wb), 256'hC3);
    chk("sim_ld_lane0", 256'(rdata_wb[0 +: 32]), 256'h8800);

    // Reset with three loads buffered
    alu_valid_x = 1'b1; alu_mask_x = 8'h01; alu_rwa_x = 10'h011; alu_data_x = mk_data(32'h1);
    mem_valid_m = 1'b1;
    for (int k = 0; k < 3; k++) begin
      set_load(k);
      tick();
    end
    chk("pre_rst_pending", 256'(mem_pending), 256'h1);
    alu_valid_x = 1'b0; mem_valid_m = 1'b0; rst = 1'b1;
    tick();
    chk("mid_rst_rwe", 256'(rwe_wb), 256'h0);
    chk("mid_rst_rwa", 256'(rwa_wb), 256'h0);
    chk("mid_rst_pending", 256'(mem_pending), 256'h0);
    chk("mid_rst_ready", 256'(mem_ready_m), 256'h0);
    rst = 1'b0; #1;
    chk("mid_rst_ready_after", 256'(mem_ready_m), 256'h1);
    tick();
    chk("flushed_rwe", 256'(rwe_wb), 256'h0);
    chk("flushed_pending", 256'(mem_pending), 256'h0);

    // Zero-mask ALU and load slots
    alu_valid_x = 1'b1; alu_mask_x = 8'h00; alu_rwa_x = 10'h3FF; alu_data_x = mk_data(32'h9);
    tick();
    alu_valid_x = 1'b0;
    chk("zm_alu_rwe", 256'(rwe_wb), 256'h0);
    chk("zm_alu_rwa", 256'(rwa_wb), 256'h3FF);
    mem_valid_m = 1'b1; mem_mask_m = 8'h00; mem_rwa_m = 10'h1F0; mem_data_m = mk_data(32'h3);
    tick();
    mem_valid_m = 1'b0;
    tick();
    chk("zm_ld_rwe", 256'(rwe_wb), 256'h0);
    chk("zm_ld_rwa", 256'(rwa_wb), 256'h1F0);
    chk("zm_ld_pending", 256'(mem_pending), 256'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
